uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Shares one uart_m transmitter (load/d/txbusy side) between NREQ byte producers, for example a debug printer, a status reporter and a command echo.
- Arbitrates round-robin, captures the winning byte, issues a single-cycle load pulse to uart_m, then tracks txbusy until the byte has left the pin.
- Sits between the producers and uart_m's TX inputs, in the same clock domain as the uart.

Parameters:
- NREQ, 3, number of requesters (2..8).
- BUSYWAIT, 4, maximum cycles to wait for txbusy to rise after load before the byte is treated as sent.

Ports:
- clk  in  1  system clock; same clock as the uart_m instance.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester byte-pending flag; held high until the matching ack.
- din  in  8*NREQ  requester bytes; byte i is din[8*i+7:8*i]; must be stable while req[i]=1.
- ack  out  NREQ  one-hot, one-cycle pulse; the byte of requester i has been captured.
- load  out  1  to uart_m load; one-cycle pulse.
- d  out  8  to uart_m d; holds the captured byte.
- txbusy  in  1  from uart_m txbusy.
- busy  out  1  high whenever the state is not IDLE.
- lastgnt  out  clog2(NREQ)  index of the most recently granted requester.

Behaviour:
- Reset values: ack=0, load=0, d=8'h00, busy=0, lastgnt=NREQ-1, state=IDLE, so requester 0 wins first after reset.
- FSM states: IDLE, LOAD, WAITHI, WAITLO.
- IDLE:
  - If any req bit is high and txbusy=0, pick the first set req bit scanning from lastgnt+1 with modulo-NREQ wrap.
  - In that cycle, register d<=din[winner], pulse ack[winner], set lastgnt<=winner, go to LOAD.
  - If txbusy=1 in IDLE (uart busy from elsewhere or after reset), do not grant.
- LOAD: load=1 for exactly one cycle, d stable; go to WAITHI with the timeout counter cleared.
- WAITHI:
  - txbusy=1 -> WAITLO.
  - Else, when the counter reaches BUSYWAIT-1 -> IDLE. This covers a uart_m that completes the byte without asserting txbusy; no deadlock is allowed.
- WAITLO: txbusy=0 -> IDLE.
- Latencies:
  - req rising in IDLE to ack: 1 cycle (registered).
  - ack to load: 1 cycle.
  - Minimum grant-to-grant spacing is 3 cycles plus the txbusy-high duration.
- Requester rules:
  - A requester deasserts req in the cycle after ack, or keeps it high to send another byte.
  - A kept-high req is not re-granted until all other pending requesters have been served once (round-robin fairness).
- Simultaneous events:
  - ack and the next req change in the same cycle: the new req is sampled only in IDLE.
  - All req bits high: strict rotation 0,1,2,0,...
- A req that drops before its ack is simply not granted; no byte is lost or duplicated.
- d changes only in the IDLE grant cycle; it is never modified during LOAD, WAITHI or WAITLO.
- Reset mid-operation returns to the reset values immediately. A byte already in uart_m is not aborted by this block.

Optional Feature:
- Macro: UART_TX_ARB_PRIO0_EN.
- Defined: requester 0 has absolute priority. If req[0]=1 in IDLE it wins regardless of lastgnt; the remaining requesters rotate round-robin among themselves, with lastgnt still updated.
- Undefined: pure round-robin as described above.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding constants (IDLE=2'd0, LOAD=2'd1, WAITHI=2'd2, WAITLO=2'd3).
  - Byte width 8.
  - The clog2 function.
- One natural sub-module: rr_pick, a purely combinational rotate-and-priority-encode taking req and lastgnt and returning a one-hot and an index. It is reusable for a future RX-byte dispatcher.

Test Plan:
- Reset, then req=3'b001 with din0=8'hC1; the bench loops uart_m TX to RX -> ack[0] 1 cycle later, a single load, and RX receives 8'hC1.
- req=3'b111 held with din={8'h4E,8'h42,8'hC1} -> grants 0,1,2,0 in order, one load per byte, no load while txbusy=1.
- txbusy stub tied 0 -> each load is followed by an IDLE return after exactly BUSYWAIT cycles, with no hang.
- Assert rst while in WAITLO -> all outputs are at reset values in the same cycle; the next grant goes to requester 0.
- req[1] raised, then dropped before ack while txbusy=1 -> no ack[1] and no load.
- With UART_TX_ARB_PRIO0_EN defined, req=3'b111 held -> requester 0 granted every time; requesters 1 and 2 are granted only when req[0]=0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, widths and helpers for the uart TX arbiter
// Contents: arb_state_e (IDLE/LOAD/WAITHI/WAITLO), BYTE_W, clog2().
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WAITHI = 2'd2,
        WAITLO = 2'd3
    } arb_state_e;

    // Index width for n items; never returns less than 1 so a 1-bit
    // index exists even for n <= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rtl/uart_tx_arb_rr_pick.sv - combinational round-robin rotate and priority encode
// Ports:
//   req    in  N   request vector
//   last   in  W   index of the previous winner; scanning starts at last+1
//   onehot out N   one-hot winner (zero when nothing requested)
//   idx    out W   winner index
//   valid  out 1   any request present
module rr_pick
    import uart_pkg::*;
#(
    parameter int N = 3,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         valid
);

    logic [W-1:0] pos;

    // Visit last+1, last+2, ... last+N (mod N); the first set bit wins,
    // so the previous winner is considered last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        pos    = '0;
        for (int k = 1; k <= N; k++) begin
            pos = W'((int'(last) + k) % N);
            if (!valid && req[pos]) begin
                valid       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one uart_m transmitter among NREQ producers
// Optional macro: UART_TX_ARB_PRIO0_EN (requester 0 has absolute priority).
// Ports:
//   clk     in  1        clock shared with uart_m
//   rst     in  1        asynchronous active-high reset
//   req     in  NREQ     byte-pending flags, held until ack
//   din     in  8*NREQ   requester bytes, byte i at din[8*i+7:8*i]
//   ack     out NREQ     one-cycle one-hot capture pulse
//   load    out 1        one-cycle load pulse to uart_m
//   d       out 8        captured byte to uart_m
//   txbusy  in  1        uart_m busy
//   busy    out 1        arbiter not idle
//   lastgnt out clog2    most recently granted requester
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int BUSYWAIT = 4,
    localparam int GW      = clog2(NREQ),
    localparam int CW      = clog2(BUSYWAIT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [BYTE_W*NREQ-1:0]   din,
    output logic [NREQ-1:0]          ack,
    output logic                     load,
    output logic [BYTE_W-1:0]        d,
    input  logic                     txbusy,
    output logic                     busy,
    output logic [GW-1:0]            lastgnt
);

    arb_state_e          state_q, state_d;
    logic [BYTE_W-1:0]   d_q, d_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                load_q, load_d;
    logic [GW-1:0]       lastgnt_q, lastgnt_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [NREQ-1:0]     rr_req;
    logic [NREQ-1:0]     rr_onehot;
    logic [GW-1:0]       rr_idx;
    logic                rr_valid;

    logic [NREQ-1:0]     win_onehot;
    logic [GW-1:0]       win_idx;
    logic                win_valid;
    logic [BYTE_W-1:0]   win_byte;

`ifdef UART_TX_ARB_PRIO0_EN
    // Requester 0 is taken out of the rotation and overrides it.
    assign rr_req = {req[NREQ-1:1], 1'b0};
`else
    assign rr_req = req;
`endif

    rr_pick #(
        .N (NREQ),
        .W (GW)
    ) u_rr_pick (
        .req    (rr_req),
        .last   (lastgnt_q),
        .onehot (rr_onehot),
        .idx    (rr_idx),
        .valid  (rr_valid)
    );

    always_comb begin
        win_onehot = rr_onehot;
        win_idx    = rr_idx;
        win_valid  = rr_valid;
`ifdef UART_TX_ARB_PRIO0_EN
        if (req[0]) begin
            win_onehot    = '0;
            win_onehot[0] = 1'b1;
            win_idx       = '0;
            win_valid     = 1'b1;
        end
`endif
    end

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) begin
                win_byte = win_byte | din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // The load pulse is registered while in LOAD, so uart_m sees it during
    // the first WAITHI cycle, one cycle after ack.
    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        ack_d     = '0;
        load_d    = 1'b0;
        lastgnt_d = lastgnt_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid && !txbusy) begin
                    d_d       = win_byte;
                    ack_d     = win_onehot;
                    lastgnt_d = win_idx;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                load_d  = 1'b1;
                cnt_d   = '0;
                state_d = WAITHI;
            end
            WAITHI: begin
                // Give up waiting for txbusy so a uart that never raises it
                // cannot wedge the arbiter.
                if (txbusy) begin
                    state_d = WAITLO;
                end else if (cnt_q == CW'(BUSYWAIT - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAITLO: begin
                if (!txbusy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            d_q       <= '0;
            ack_q     <= '0;
            load_q    <= 1'b0;
            lastgnt_q <= GW'(NREQ - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            ack_q     <= ack_d;
            load_q    <= load_d;
            lastgnt_q <= lastgnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ack     = ack_q;
    assign load    = load_q;
    assign d       = d_q;
    assign busy    = (state_q != IDLE);
    assign lastgnt = lastgnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] din;
    logic [2:0]  ack;
    logic        load;
    logic [7:0]  d;
    logic        txbusy;
    logic        busy;
    logic [1:0]  lastgnt;

    int checks = 0;
    int errors = 0;

    // uart_m stand-in: stub_mode=1 raises txbusy the cycle after load for
    // stub_len cycles; stub_mode=0 drives txbusy from txbusy_force.
    logic stub_mode;
    logic stub_busy;
    logic txbusy_force;
    int   stub_phase;
    int   stub_cnt;
    int   stub_len;

    logic [2:0] ack_log[$];
    logic [7:0] rx_log[$];
    int         load_cnt;
    int         bad_load;

    int base_ack;
    int base_load;
    int n;

    assign txbusy = stub_mode ? stub_busy : txbusy_force;

    uart_tx_arb #(
        .NREQ     (3),
        .BUSYWAIT (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .ack     (ack),
        .load    (load),
        .d       (d),
        .txbusy  (txbusy),
        .busy    (busy),
        .lastgnt (lastgnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        stub_busy  = 1'b0;
        stub_phase = 0;
        stub_cnt   = 0;
        load_cnt   = 0;
        bad_load   = 0;
    end

    always @(negedge clk) begin
        if (ack != 3'b000) ack_log.push_back(ack);
        if (load) begin
            load_cnt = load_cnt + 1;
            rx_log.push_back(d);
            if (txbusy) bad_load = bad_load + 1;
        end
        if (load) begin
            stub_phase = 1;
        end else if (stub_phase == 1) begin
            stub_busy  = 1'b1;
            stub_cnt   = stub_len - 1;
            stub_phase = 2;
        end else if (stub_phase == 2) begin
            if (stub_cnt == 0) begin
                stub_busy  = 1'b0;
                stub_phase = 0;
            end else begin
                stub_cnt = stub_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy) break;
            tick();
        end
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        rst          = 1'b1;
        req          = 3'b000;
        din          = {8'h4E, 8'h42, 8'hC1};
        stub_mode    = 1'b1;
        stub_len     = 5;
        txbusy_force = 1'b0;
        tick();
        tick();

        chk("rst_ack", 32'(ack), 0);
        chk("rst_load", 32'(load), 0);
        chk("rst_d", 32'(d), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lastgnt", 32'(lastgnt), 2);
        rst = 1'b0;
        tick();

        // Single byte from requester 0.
        base_load = load_cnt;
        req = 3'b001;
        tick();
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_d", 32'(d), 32'hC1);
        chk("t1_lastgnt", 32'(lastgnt), 0);
        chk("t1_load_early", 32'(load), 0);
        req = 3'b000;
        tick();
        chk("t1_load", 32'(load), 1);
        chk("t1_ack_clear", 32'(ack), 0);
        wait_idle("t1_idle", 60);
        chk("t1_rx", 32'(rx_log[rx_log.size()-1]), 32'hC1);
        chk("t1_loads", load_cnt - base_load, 1);

        // All requesters held after a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base_ack  = ack_log.size();
        base_load = load_cnt;
        req = 3'b111;
        for (int i = 0; i < 300; i++) begin
            if (ack_log.size() - base_ack >= 4) break;
            tick();
        end
        req = 3'b000;
        chk("t2_ack_count", ack_log.size() - base_ack, 4);
        wait_idle("t2_idle", 60);
`ifdef UART_TX_ARB_PRIO0_EN
        chk("t2_g0", 32'(ack_log[base_ack+0]), 32'h1);
        chk("t2_g1", 32'(ack_log[base_ack+1]), 32'h1);
        chk("t2_g2", 32'(ack_log[base_ack+2]), 32'h1);
        chk("t2_g3", 32'(ack_log[base_ack+3]), 32'h1);
        chk("t2_rx1", 32'(rx_log[base_load+1]), 32'hC1);
        chk("t2_rx2", 32'(rx_log[base_load+2]), 32'hC1);
`else
        chk("t2_g0", 32'(ack_log[base_ack+0]), 32'h1);
        chk("t2_g1", 32'(ack_log[base_ack+1]), 32'h2);
        chk("t2_g2", 32'(ack_log[base_ack+2]), 32'h4);
        chk("t2_g3", 32'(ack_log[base_ack+3]), 32'h1);
        chk("t2_rx1", 32'(rx_log[base_load+1]), 32'h42);
        chk("t2_rx2", 32'(rx_log[base_load+2]), 32'h4E);
`endif
        chk("t2_loads", load_cnt - base_load, 4);
        chk("t2_no_load_busy", bad_load, 0);

        // Without requester 0, requester 1 follows a grant to 0.
        req = 3'b110;
        tick();
        chk("t2b_ack", 32'(ack), 32'h2);
        req = 3'b000;
        wait_idle("t2b_idle", 60);

        // txbusy never rises: WAITHI times out after BUSYWAIT cycles.
        stub_mode    = 1'b0;
        txbusy_force = 1'b0;
        req = 3'b100;
        tick();
        chk("t3_ack", 32'(ack), 32'h4);
        req = 3'b000;
        tick();
        chk("t3_load", 32'(load), 1);
        chk("t3_d", 32'(d), 32'h4E);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
            n = n + 1;
        end
        chk("t3_timeout_len", n, 4);

        // Reset while in WAITLO.
        req = 3'b001;
        tick();
        chk("t4_ack", 32'(ack), 32'h1);
        req = 3'b000;
        tick();
        chk("t4_load", 32'(load), 1);
        txbusy_force = 1'b1;
        tick();
        tick();
        chk("t4_waitlo_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t4_rst_ack", 32'(ack), 0);
        chk("t4_rst_load", 32'(load), 0);
        chk("t4_rst_d", 32'(d), 0);
        chk("t4_rst_busy", 32'(busy), 0);
        chk("t4_rst_lastgnt", 32'(lastgnt), 2);
        tick();
        rst = 1'b0;
        txbusy_force = 1'b0;
        req = 3'b011;
        tick();
        chk("t4_next_grant", 32'(ack), 32'h1);
        req = 3'b000;
        wait_idle("t4_idle", 60);

        // req[1] withdrawn while the uart is busy from elsewhere.
        base_ack  = ack_log.size();
        base_load = load_cnt;
        txbusy_force = 1'b1;
        req = 3'b010;
        tick();
        tick();
        tick();
        chk("t5_no_ack", 32'(ack), 0);
        chk("t5_idle", 32'(busy), 0);
        req = 3'b000;
        txbusy_force = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_ack_log", ack_log.size() - base_ack, 0);
        chk("t5_no_load", load_cnt - base_load, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
